// File: rtl/ucode_sequencer_pkg.sv
// Shared types and opcode constants for the microcode sequencer and its decoder.
package ucode_pkg;

    // Single-byte opcodes with a fixed meaning
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_RET  = 8'h0B;

    // Port moves: 40+p writes port p, 48+p reads port p into W
    localparam logic [7:0] OP_MOV_WP_BASE = 8'h40;
    localparam logic [7:0] OP_MOV_PW_BASE = 8'h48;

    // Register moves: 50+r writes register r, 58+r reads register r into W
    localparam logic [7:0] OP_MOV_WR_BASE = 8'h50;
    localparam logic [7:0] OP_MOV_RW_BASE = 8'h58;

    // Control-transfer opcodes (all two-byte, target in the operand)
    localparam logic [7:0] OP_JMP_LO  = 8'hA2;
    localparam logic [7:0] OP_JMP_HI  = 8'hA3;
    localparam logic [7:0] OP_JC_LO   = 8'hA4;
    localparam logic [7:0] OP_JC_HI   = 8'hA5;
    localparam logic [7:0] OP_JZ_LO   = 8'hA6;
    localparam logic [7:0] OP_JZ_HI   = 8'hA7;
    localparam logic [7:0] OP_CALL_LO = 8'hA8;
    localparam logic [7:0] OP_CALL_HI = 8'hA9;

    // The 12 operation-class, destination and illegal flags of a decoded opcode
    typedef struct packed {
        logic alu_op;
        logic alu_mb;
        logic mov_op;
        logic jmp_op;
        logic call_op;
        logic ret_op;
        logic dst_w;
        logic dst_f;
        logic dst_mem;
        logic dst_reg;
        logic dst_port;
        logic illegal;
    } ucode_ctrl_t;

    // Sequencer states
    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        ISSUE     = 2'd2
    } ucode_state_t;

endpackage

// File: rtl/ucode_sequencer_if.sv
// Fetch byte stream and execute-stage bundle handshake of the sequencer.
// master is the sequencer's view; slave is the surrounding fetch/execute logic.
interface ucode_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_opcode;
    logic [7:0] out_operand;
    logic [2:0] out_index;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_opcode, out_operand, out_index
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_operand, out_index
    );
endinterface

// File: rtl/ucode_sequencer_decode.sv
// Purely combinational opcode decoder; the sequencer registers its outputs.
module ucode_decode
    import ucode_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int NUM_REGS  = 8
) (
    input  logic [7:0]  i_opcode,
    input  logic [7:0]  i_w,
    input  logic        i_carry,
    input  logic        i_zero,
    output ucode_ctrl_t o_ctrl,
    output logic        o_jmpTaken
);

    logic w_portOk;
    logic w_regOk;

    assign w_portOk = (32'(i_opcode[2:0]) < NUM_PORTS);
    assign w_regOk  = (32'(i_opcode[2:0]) < NUM_REGS);

    // Map each opcode to its flag set; anything unlisted is flagged illegal
    always_comb begin
        o_ctrl     = '0;
        o_jmpTaken = 1'b0;
        case (i_opcode) inside
            OP_NOP: o_ctrl = '0;
            [8'h01:8'h03], [8'h06:8'h0A], [8'h60:8'h6F],
            [8'h88:8'h8F], [8'h94:8'h9F]: begin
                o_ctrl.alu_op = 1'b1;
                o_ctrl.dst_w  = 1'b1;
            end
            [8'h04:8'h05]: begin
                o_ctrl.alu_op = 1'b1;
                o_ctrl.dst_f  = 1'b1;
            end
            OP_RET: o_ctrl.ret_op = 1'b1;
            [OP_MOV_WP_BASE:OP_MOV_WP_BASE + 8'd7]: begin
                o_ctrl.mov_op   = w_portOk;
                o_ctrl.dst_port = w_portOk;
                o_ctrl.illegal  = !w_portOk;
            end
            [OP_MOV_PW_BASE:OP_MOV_PW_BASE + 8'd7]: begin
                o_ctrl.mov_op  = w_portOk;
                o_ctrl.dst_w   = w_portOk;
                o_ctrl.illegal = !w_portOk;
            end
            [OP_MOV_WR_BASE:OP_MOV_WR_BASE + 8'd7]: begin
                o_ctrl.mov_op  = w_regOk;
                o_ctrl.dst_reg = w_regOk;
                o_ctrl.illegal = !w_regOk;
            end
            [OP_MOV_RW_BASE:OP_MOV_RW_BASE + 8'd7]: begin
                o_ctrl.mov_op  = w_regOk;
                o_ctrl.dst_w   = w_regOk;
                o_ctrl.illegal = !w_regOk;
            end
            8'h80, 8'h81, 8'h84, 8'h85: begin
                o_ctrl.mov_op = 1'b1;
                o_ctrl.dst_w  = 1'b1;
            end
            8'h82, 8'h83, 8'h86, 8'h87: begin
                o_ctrl.mov_op  = 1'b1;
                o_ctrl.dst_mem = 1'b1;
            end
            [8'h90:8'h93]: begin
                o_ctrl.alu_op  = 1'b1;
                o_ctrl.alu_mb  = 1'b1;
                o_ctrl.dst_w   = 1'b1;
                o_ctrl.dst_mem = 1'b1;
            end
            8'hA0, 8'hA1: begin
                o_ctrl.mov_op  = 1'b1;
                o_ctrl.dst_w   = 1'b1;
                o_ctrl.dst_mem = 1'b1;
            end
            OP_JMP_LO, OP_JMP_HI: begin
                o_ctrl.jmp_op = 1'b1;
                o_jmpTaken    = 1'b1;
            end
            OP_JC_LO, OP_JC_HI: begin
                o_ctrl.jmp_op = 1'b1;
                o_jmpTaken    = i_carry;
            end
            OP_JZ_LO, OP_JZ_HI: begin
                o_ctrl.jmp_op = 1'b1;
                o_jmpTaken    = i_zero;
            end
            OP_CALL_LO, OP_CALL_HI: begin
                o_ctrl.jmp_op  = 1'b1;
                o_ctrl.call_op = 1'b1;
                o_jmpTaken     = 1'b1;
            end
            [8'hE0:8'hEF]: begin
                o_ctrl.jmp_op = 1'b1;
                o_jmpTaken    = !i_w[i_opcode[3:1]];
            end
            [8'hF0:8'hFF]: begin
                o_ctrl.jmp_op = 1'b1;
                o_jmpTaken    = i_w[i_opcode[3:1]];
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ucode_sequencer.sv
// Multi-cycle microcode sequencer: collects opcode/operand bytes, issues a
// registered control bundle under valid/ready, and keeps a CALL/RET stack.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int NUM_PORTS   = 2,
    parameter int NUM_REGS    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    ucode_sequencer_if.master bus,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [7:0]        w,
    input  logic              carry,
    input  logic              zero,
    output logic              alu_op,
    output logic              alu_mb,
    output logic              mov_op,
    output logic              jmp_op,
    output logic              jmp_taken,
    output logic              call_op,
    output logic              ret_op,
    output logic              dst_w,
    output logic              dst_f,
    output logic              dst_mem,
    output logic              dst_reg,
    output logic              dst_port,
    output logic              illegal,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              stack_ovf,
    output logic              stack_unf
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ucode_state_t      r_state;
    logic              r_inReady;
    logic              r_outValid;
    logic [7:0]        r_opcode;
    logic [7:0]        r_operand;
    ucode_ctrl_t       r_ctrl;
    logic              r_jmpTaken;
    logic [ADDR_W-1:0] r_retAddr;
    logic [ADDR_W-1:0] r_pushAddr;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_unf;

    logic [7:0]        w_decOpcode;
    ucode_ctrl_t       w_decCtrl;
    logic              w_decTaken;
    logic              w_lastByte;
    logic              w_handshake;
    logic [CNT_W-1:0]  w_topCount;
    logic [ADDR_W-1:0] w_topAddr;

    // While fetching the opcode the decoder sees the live byte, otherwise the latched one
    assign w_decOpcode = (r_state == FETCH_OP) ? bus.in_data : r_opcode;
    assign w_lastByte  = bus.in_valid &&
                         (((r_state == FETCH_OP) && !bus.in_data[7]) || (r_state == FETCH_ARG));
    assign w_handshake = r_outValid && bus.out_ready;
    assign w_topCount  = r_count - CNT_W'(1);
    assign w_topAddr   = (r_count == '0) ? '0 : r_stack[w_topCount[PTR_W-1:0]];

    ucode_decode #(
        .NUM_PORTS (NUM_PORTS),
        .NUM_REGS  (NUM_REGS)
    ) u_decode (
        .i_opcode   (w_decOpcode),
        .i_w        (w),
        .i_carry    (carry),
        .i_zero     (zero),
        .o_ctrl     (w_decCtrl),
        .o_jmpTaken (w_decTaken)
    );

    // Byte-collection FSM; the bundle, flag samples and return address latch on the last byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH_OP;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_opcode   <= '0;
            r_operand  <= '0;
            r_ctrl     <= '0;
            r_jmpTaken <= 1'b0;
            r_retAddr  <= '0;
            r_pushAddr <= '0;
        end else begin
            if (w_lastByte) begin
                r_ctrl     <= w_decCtrl;
                r_jmpTaken <= w_decTaken;
                r_retAddr  <= w_decCtrl.ret_op ? w_topAddr : '0;
                r_pushAddr <= pc_in;
            end
            case (r_state)
                FETCH_OP: begin
                    if (bus.in_valid) begin
                        r_opcode <= bus.in_data;
                        if (bus.in_data[7]) begin
                            r_state <= FETCH_ARG;
                        end else begin
                            r_operand  <= '0;
                            r_state    <= ISSUE;
                            r_inReady  <= 1'b0;
                            r_outValid <= 1'b1;
                        end
                    end
                end
                FETCH_ARG: begin
                    if (bus.in_valid) begin
                        r_operand  <= bus.in_data;
                        r_state    <= ISSUE;
                        r_inReady  <= 1'b0;
                        r_outValid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.out_ready) begin
                        r_state    <= FETCH_OP;
                        r_inReady  <= 1'b1;
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= FETCH_OP;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    // Return stack commits push/pop only when the execute stage takes the bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_handshake) begin
            if (r_ctrl.call_op) begin
                if (r_count == CNT_W'(STACK_DEPTH)) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_stack[r_count[PTR_W-1:0]] <= r_pushAddr;
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (r_ctrl.ret_op) begin
                if (r_count == '0) begin
                    r_unf <= 1'b1;
                end else begin
                    r_count <= w_topCount;
                end
            end
        end
    end

    assign bus.in_ready    = r_inReady;
    assign bus.out_valid   = r_outValid;
    assign bus.out_opcode  = r_opcode;
    assign bus.out_operand = r_operand;
    assign bus.out_index   = r_opcode[2:0];

    assign alu_op    = r_ctrl.alu_op;
    assign alu_mb    = r_ctrl.alu_mb;
    assign mov_op    = r_ctrl.mov_op;
    assign jmp_op    = r_ctrl.jmp_op;
    assign jmp_taken = r_jmpTaken;
    assign call_op   = r_ctrl.call_op;
    assign ret_op    = r_ctrl.ret_op;
    assign dst_w     = r_ctrl.dst_w;
    assign dst_f     = r_ctrl.dst_f;
    assign dst_mem   = r_ctrl.dst_mem;
    assign dst_reg   = r_ctrl.dst_reg;
    assign dst_port  = r_ctrl.dst_port;
    assign illegal   = r_ctrl.illegal;
    assign ret_addr  = r_retAddr;
    assign stack_ovf = r_ovf;
    assign stack_unf = r_unf;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed self-checking bench for ucode_sequencer (default parameters).
module tb_ucode_sequencer;

    localparam logic [12:0] F_ALU   = 13'h1000;
    localparam logic [12:0] F_MB    = 13'h0800;
    localparam logic [12:0] F_MOV   = 13'h0400;
    localparam logic [12:0] F_JMP   = 13'h0200;
    localparam logic [12:0] F_TAKEN = 13'h0100;
    localparam logic [12:0] F_CALL  = 13'h0080;
    localparam logic [12:0] F_RET   = 13'h0040;
    localparam logic [12:0] F_DW    = 13'h0020;
    localparam logic [12:0] F_DF    = 13'h0010;
    localparam logic [12:0] F_DMEM  = 13'h0008;
    localparam logic [12:0] F_DREG  = 13'h0004;
    localparam logic [12:0] F_DPORT = 13'h0002;
    localparam logic [12:0] F_ILL   = 13'h0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pcIn = '0;
    logic [7:0] wReg = '0;
    logic       carry = 1'b0;
    logic       zero = 1'b0;
    logic       aluOp, aluMb, movOp, jmpOp, jmpTaken, callOp, retOp;
    logic       dstW, dstF, dstMem, dstReg, dstPort, illegal;
    logic [7:0] retAddr;
    logic       stackOvf, stackUnf;
    logic [12:0] flags;

    int checks = 0;
    int failures = 0;

    ucode_sequencer_if bus();

    ucode_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .pc_in     (pcIn),
        .w         (wReg),
        .carry     (carry),
        .zero      (zero),
        .alu_op    (aluOp),
        .alu_mb    (aluMb),
        .mov_op    (movOp),
        .jmp_op    (jmpOp),
        .jmp_taken (jmpTaken),
        .call_op   (callOp),
        .ret_op    (retOp),
        .dst_w     (dstW),
        .dst_f     (dstF),
        .dst_mem   (dstMem),
        .dst_reg   (dstReg),
        .dst_port  (dstPort),
        .illegal   (illegal),
        .ret_addr  (retAddr),
        .stack_ovf (stackOvf),
        .stack_unf (stackUnf)
    );

    assign flags = {aluOp, aluMb, movOp, jmpOp, jmpTaken, callOp, retOp,
                    dstW, dstF, dstMem, dstReg, dstPort, illegal};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one byte and hold it until the sequencer accepts it (bounded)
    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("in_ready_timeout", 32'(n < 20), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_flags", 32'(flags), 32'd0);
        checkOutput("rst_ret_addr", 32'(retAddr), 32'd0);
        checkOutput("rst_err", 32'({stackOvf, stackUnf}), 32'd0);

        // Single-byte ALU op with execute ready
        bus.out_ready = 1'b1;
        applyStimulus(8'h02);
        checkOutput("b02_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("b02_flags", 32'(flags), 32'(F_ALU | F_DW));
        checkOutput("b02_operand", 32'(bus.out_operand), 32'h00);
        checkOutput("b02_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        checkOutput("b02_done_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("b02_done_in_ready", 32'(bus.in_ready), 32'd1);

        // Two-byte op held under back-pressure
        bus.out_ready = 1'b0;
        applyStimulus(8'h88);
        checkOutput("b88_in_ready_arg", 32'(bus.in_ready), 32'd1);
        applyStimulus(8'h5A);
        for (int i = 0; i < 3; i++) begin
            checkOutput("b88_hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("b88_hold_operand", 32'(bus.out_operand), 32'h5A);
            checkOutput("b88_hold_flags", 32'(flags), 32'(F_ALU | F_DW));
            checkOutput("b88_hold_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checkOutput("b88_release_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("b88_release_in_ready", 32'(bus.in_ready), 32'd1);

        // Port index range with two ports
        applyStimulus(8'h42);
        checkOutput("b42_flags", 32'(flags), 32'(F_ILL));
        tick();
        applyStimulus(8'h41);
        checkOutput("b41_flags", 32'(flags), 32'(F_MOV | F_DPORT));
        checkOutput("b41_index", 32'(bus.out_index), 32'd1);
        tick();
        applyStimulus(8'h57);
        checkOutput("b57_flags", 32'(flags), 32'(F_MOV | F_DREG));
        tick();
        applyStimulus(8'h05);
        checkOutput("b05_flags", 32'(flags), 32'(F_ALU | F_DF));
        tick();
        applyStimulus(8'h91);
        applyStimulus(8'h33);
        checkOutput("b91_flags", 32'(flags), 32'(F_ALU | F_MB | F_DW | F_DMEM));
        checkOutput("b91_opcode", 32'(bus.out_opcode), 32'h91);
        tick();

        // Test-bit jumps: bit 3 of W
        wReg = 8'h08;
        applyStimulus(8'hF6);
        applyStimulus(8'h10);
        checkOutput("bF6_flags", 32'(flags), 32'(F_JMP | F_TAKEN));
        tick();
        applyStimulus(8'hE6);
        applyStimulus(8'h10);
        checkOutput("bE6_flags", 32'(flags), 32'(F_JMP));
        tick();
        bus.out_ready = 1'b0;
        applyStimulus(8'hF6);
        applyStimulus(8'h10);
        wReg = 8'h00;
        tick();
        checkOutput("bF6_w_change_taken", 32'(jmpTaken), 32'd1);
        bus.out_ready = 1'b1;
        tick();

        // Carry-conditional jump
        carry = 1'b1;
        applyStimulus(8'hA4);
        applyStimulus(8'h20);
        checkOutput("bA4_c1_flags", 32'(flags), 32'(F_JMP | F_TAKEN));
        tick();
        carry = 1'b0;
        applyStimulus(8'hA4);
        applyStimulus(8'h20);
        checkOutput("bA4_c0_flags", 32'(flags), 32'(F_JMP));
        tick();

        // Five CALLs into a 4-deep stack
        for (int i = 0; i < 5; i++) begin
            pcIn = 8'h10 + 8'(i);
            applyStimulus(8'hA8);
            applyStimulus(8'h40);
            checkOutput("call_flags", 32'(flags), 32'(F_JMP | F_TAKEN | F_CALL));
            tick();
            checkOutput("call_ovf", 32'(stackOvf), 32'(i == 4));
        end

        // Four RETs unwind in reverse order, the fifth underflows
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h0B);
            checkOutput("ret_flags", 32'(flags), 32'(F_RET));
            checkOutput("ret_addr", 32'(retAddr), (i < 4) ? 32'(8'h13 - 8'(i)) : 32'd0);
            tick();
            checkOutput("ret_unf", 32'(stackUnf), 32'(i == 4));
        end

        // Leave one entry on the stack, then reset in the middle of a two-byte op
        pcIn = 8'h20;
        applyStimulus(8'hA8);
        applyStimulus(8'h00);
        tick();
        applyStimulus(8'h84);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mid_rst_err", 32'({stackOvf, stackUnf}), 32'd0);
        applyStimulus(8'h01);
        checkOutput("post_rst_flags", 32'(flags), 32'(F_ALU | F_DW));
        checkOutput("post_rst_opcode", 32'(bus.out_opcode), 32'h01);
        checkOutput("post_rst_operand", 32'(bus.out_operand), 32'h00);
        tick();
        applyStimulus(8'h0B);
        checkOutput("post_rst_ret_addr", 32'(retAddr), 32'd0);
        tick();
        checkOutput("post_rst_unf", 32'(stackUnf), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
